aors_accum: RTL and testbench
=============================

// Module: aors_accum
// PURPOSE
//  Downstream stage of the 4-bit add/subtract unit. Accepts its 5-bit results over
//  a valid/ready handshake and sums a frame of N_SAMPLES results in a signed,
//  saturating accumulator. Presents each frame total on a held output handshake.
//  Turns the combinational add/sub datapath into a framed running-sum producer.
// PARAMETERS
//  N_SAMPLES  4  results summed per frame; range 2..16
//  ACC_W      7  accumulator/output width, signed two's complement; must be >= 6
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  clear      in   1      synchronous frame abort
//  in_valid   in   1      in_data/in_sub valid this cycle
//  in_ready   out  1      stage can accept a result this cycle
//  in_data    in   5      add/sub unit result
//  in_sub     in   1      1 = in_data came from a subtract
//  out_valid  out  1      out_data/out_sat hold a completed frame
//  out_ready  in   1      consumer takes the frame this cycle
//  out_data   out  ACC_W  frame total, signed
//  out_sat    out  1      saturation occurred at some step of this frame
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=ACC, count=0, acc=0, sat=0.
//    Outputs: out_valid=0, out_data=0, out_sat=0, in_ready=1.
//  Input extension:
//    in_sub=0: in_data is zero-extended to ACC_W (range 0..31).
//    in_sub=1: in_data is sign-extended to ACC_W (range -16..15).
//  Accept rule: accept = in_valid & in_ready.
//  in_ready is registered state, not combinational: in_ready = (state==ACC).
//  Each accept computes acc_next = sat(acc + ext(in_data)), applied per step.
//    Result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//    A clamp sets the sticky sat bit for the frame.
//  States:
//    ACC  : on accept with count<N_SAMPLES-1, acc<=acc_next and count++.
//           On accept with count==N_SAMPLES-1, out_data<=acc_next and
//           out_sat<=sat|clamp_now. Then out_valid<=1, acc<=0, sat<=0,
//           count<=0, and state -> HOLD.
//    HOLD : in_ready=0, so in_valid is ignored. out_data/out_sat stay stable.
//           When out_valid & out_ready: out_valid<=0 and state -> ACC.
//           The first new accept is possible the cycle after that.
//  Latency: out_valid rises one clk after the final accept of a frame.
//  clear=1: acc=0, count=0, sat=0, out_valid=0, state -> ACC.
//    clear overrides any accept or output handshake in the same cycle.
//    rst_n overrides clear.
//  Reset mid-frame or in HOLD: the partial or pending frame is discarded.
//  out_data/out_sat retain their last frame value after handoff.
//    They are only meaningful while out_valid=1.
// STRUCTURE
//  aors_pkg holds shared constants:
//    state encodings ST_ACC=1'b0, ST_HOLD=1'b1
//    default N_SAMPLES and ACC_W
//    the input width IN_W=5, shared with the add/sub unit
//  One sub-module, sat_add:
//    combinational, ACC_W-bit signed saturating adder
//    outputs sum and clamp flag
//  Top level holds the FSM, counter, registers and sign/zero extension.
// TESTING (ACC_W=7, N_SAMPLES=4)
//  1 Reset: hold rst_n=0 for 2 clk with in_valid=1.
//    -> out_valid=0, in_ready=1, nothing accepted.
//  2 Add frame: in_sub=0, data 24,12,16,1 back-to-back.
//    -> out_valid next clk, out_data=7'b0110101 (53), out_sat=0.
//  3 Subtract frame: in_sub=1, data 5'b11110 x4.
//    -> out_data=7'b1111000 (-8), out_sat=0.
//  4 Saturation: in_sub=0, data 31 x4.
//    -> steps 31, 62, 63 (clamp), 63; out_data=63, out_sat=1.
//    Next frame: in_sub=1, data 5'b10000 x4 -> out_data=-64, out_sat=0.
//  5 Backpressure: complete a frame, hold out_ready=0 for 5 clk with in_valid=1.
//    -> in_ready=0, out_data stable, no accepts.
//    Then out_ready=1 -> out_valid drops, in_ready=1 next clk.
//  6 Clear: 2 accepts, pulse clear, then accepts of 1,1,1,1.
//    -> out_data=4.
//    Also: clear in the same clk as a 4th accept -> no frame emitted.

Source files
------------

// File: rtl/aors_pkg.sv
// aors_pkg: constants shared by the add/sub result accumulator.
// State encodings, default sizes and the add/sub unit result width.
package aors_pkg;

  localparam int IN_W          = 5;
  localparam int N_SAMPLES_DEF = 4;
  localparam int ACC_W_DEF     = 7;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sat_add.sv
// sat_add: W-bit signed saturating adder.
// Clamps to the signed range and flags when it did so.
module sat_add #(
  parameter int W = 7
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                clamp
);

  logic signed [W:0] full;

  assign full = {a[W-1], a} + {b[W-1], b};

  // overflow when the two top bits of the widened sum disagree
  always_comb begin
    sum   = full[W-1:0];
    clamp = 1'b0;
    if (full[W] != full[W-1]) begin
      clamp = 1'b1;
      if (full[W]) sum = {1'b1, {(W-1){1'b0}}};
      else         sum = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/aors_accum.sv
// aors_accum: framed signed saturating sum of add/sub results.
// Each frame total is held on the output until the consumer takes it.
module aors_accum
  import aors_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic               sat, sat_d;
  logic               out_valid_d;
  logic [ACC_W-1:0]   out_data_d;
  logic               out_sat_d;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   sum;
  logic               clamp;
  logic               accept;

  assign in_ready = (state == ST_ACC);
  assign accept   = in_valid & in_ready;

  // subtract results are signed, add results are unsigned
  assign ext = in_sub
    ? {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data}
    : {{(ACC_W-IN_W){1'b0}}, in_data};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a     (acc),
    .b     (ext),
    .sum   (sum),
    .clamp (clamp)
  );

  // next-state and datapath updates; clear wins over everything
  always_comb begin
    state_d     = state;
    count_d     = count;
    acc_d       = acc;
    sat_d       = sat;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    case (state)
      ST_ACC: begin
        if (accept) begin
          if (count == LAST) begin
            out_data_d  = sum;
            out_sat_d   = sat | clamp;
            out_valid_d = 1'b1;
            acc_d       = '0;
            sat_d       = 1'b0;
            count_d     = '0;
            state_d     = ST_HOLD;
          end else begin
            acc_d   = sum;
            sat_d   = sat | clamp;
            count_d = count + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
    if (clear) begin
      acc_d       = '0;
      count_d     = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      count     <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      acc       <= acc_d;
      sat       <= sat_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sat   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_aors_accum.sv
// tb_aors_accum: scoreboard bench for aors_accum.
// Frame totals are modelled on send and compared on output.
module tb_aors_accum;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       out_sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t q[$];

  int m_acc = 0;
  bit m_sat = 0;
  int m_cnt = 0;

  aors_accum #(.N_SAMPLES(4), .ACC_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = 0;
    m_sat = 0;
    m_cnt = 0;
  endtask

  task automatic model_accept(input logic [4:0] d, input logic s);
    int v;
    exp_t e;
    v = s ? int'($signed(d)) : int'(d);
    m_acc = m_acc + v;
    if (m_acc > 63) begin
      m_acc = 63;
      m_sat = 1;
    end else if (m_acc < -64) begin
      m_acc = -64;
      m_sat = 1;
    end
    if (m_cnt == 3) begin
      e.data = m_acc;
      e.sat  = m_sat;
      q.push_back(e);
      model_reset();
    end else begin
      m_cnt++;
    end
  endtask

  task automatic send(input logic [4:0] d, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1;
    in_data  = d;
    in_sub   = s;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
    end else begin
      model_accept(d, s);
    end
  endtask

  task automatic take_frame();
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL latency got %0d extra clk want 0", n);
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got out_data=%0d want none", out_data);
    end else begin
      e = q.pop_front();
      checks++;
      if (out_data !== 7'(e.data)) begin
        errors++;
        $display("FAIL out_data got %0d want %0d",
                 $signed(out_data), e.data);
      end
      checks++;
      if (out_sat !== e.sat) begin
        errors++;
        $display("FAIL out_sat got %0b want %0b", out_sat, e.sat);
      end
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff out_valid=%0b in_ready=%0b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 0;
    clear     = 0;
    in_valid  = 1;
    in_data   = 5'd9;
    in_sub    = 0;
    out_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs out_valid=%0b in_ready=%0b want 0 1",
               out_valid, in_ready);
    end
    checks++;
    if (out_data !== 7'd0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_out out_data=%0d out_sat=%0b want 0 0",
               out_data, out_sat);
    end
    in_valid = 0;
    rst_n    = 1;
    model_reset();
    send(5'd1, 0);
    send(5'd1, 0);
    send(5'd1, 0);
    send(5'd1, 0);
    take_frame();
  endtask

  task automatic test_add();
    send(5'd24, 0);
    send(5'd12, 0);
    send(5'd16, 0);
    send(5'd1, 0);
    take_frame();
  endtask

  task automatic test_sub();
    repeat (4) send(5'b11110, 1);
    take_frame();
  endtask

  task automatic test_saturate();
    repeat (4) send(5'd31, 0);
    take_frame();
    repeat (4) send(5'b10000, 1);
    take_frame();
  endtask

  task automatic test_backpressure();
    exp_t e;
    send(5'd3, 0);
    send(5'd5, 1);
    send(5'd7, 0);
    send(5'd9, 0);
    @(negedge clk);
    in_valid = 1;
    in_data  = 5'd7;
    in_sub   = 0;
    e = q[0];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 7'(e.data)) begin
        errors++;
        $display("FAIL hold in_ready=%0b out_valid=%0b out_data=%0d want 0 1 %0d",
                 in_ready, out_valid, $signed(out_data), e.data);
      end
      @(negedge clk);
    end
    in_valid = 0;
    take_frame();
    send(5'd2, 0);
    send(5'd2, 0);
    send(5'd2, 0);
    send(5'd2, 0);
    take_frame();
  endtask

  task automatic test_clear();
    send(5'd10, 0);
    send(5'd20, 0);
    @(negedge clk);
    in_valid = 0;
    clear    = 1;
    @(negedge clk);
    clear = 0;
    model_reset();
    repeat (4) send(5'd1, 0);
    take_frame();
    repeat (3) send(5'd2, 0);
    @(negedge clk);
    in_valid = 1;
    in_data  = 5'd2;
    in_sub   = 0;
    clear    = 1;
    @(negedge clk);
    in_valid = 0;
    clear    = 0;
    model_reset();
    repeat (3) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL clear_last out_valid=%0b in_ready=%0b want 0 1",
                 out_valid, in_ready);
      end
      @(negedge clk);
    end
    send(5'd3, 0);
    send(5'd3, 0);
    send(5'd3, 0);
    send(5'd3, 0);
    take_frame();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_saturate();
    test_backpressure();
    test_clear();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d frames want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
